// File: rtl/iob_cache_wrap_cnt.sv
// Beat sequencer for a line refill: counts acknowledged beats and offsets
// them by the starting beat so the fill wraps around the line boundary.
module iob_cache_wrap_cnt #(
    parameter int LINE2BE_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    input  logic [LINE2BE_W-1:0] start_beat,
    output logic [LINE2BE_W-1:0] beat,
    output logic                 last
);

    logic [LINE2BE_W-1:0] cnt;

    // Beats acknowledged so far in the current fill; restarts on each new refill.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + LINE2BE_W'(1);
        end
    end

    // Natural overflow of the LINE2BE_W-bit sum gives the modulo-NBEATS wrap.
    assign beat = start_beat + cnt;
    assign last = &cnt;

endmodule

// File: rtl/iob_cache_read_channel_wrap.sv
// Cache line refill read channel: fetches one line from the back-end beat by
// beat, optionally starting at the missed beat (critical word first) and
// wrapping, and writes each beat into the line with a registered write port.

// Defaults normally come from the shared iob_cache_conf.vh; these fallbacks
// keep the module usable when that header has not already been included.
`ifndef IOB_CACHE_ADDR_W
`define IOB_CACHE_ADDR_W 24
`endif
`ifndef IOB_CACHE_DATA_W
`define IOB_CACHE_DATA_W 32
`endif
`ifndef IOB_CACHE_BE_ADDR_W
`define IOB_CACHE_BE_ADDR_W 24
`endif
`ifndef IOB_CACHE_BE_DATA_W
`define IOB_CACHE_BE_DATA_W 32
`endif
`ifndef IOB_CACHE_WORD_OFFSET_W
`define IOB_CACHE_WORD_OFFSET_W 2
`endif

module iob_cache_read_channel_wrap #(
    parameter int FE_ADDR_W     = `IOB_CACHE_ADDR_W,
    parameter int FE_DATA_W     = `IOB_CACHE_DATA_W,
    parameter int BE_ADDR_W     = `IOB_CACHE_BE_ADDR_W,
    parameter int BE_DATA_W     = `IOB_CACHE_BE_DATA_W,
    parameter int WORD_OFFSET_W = `IOB_CACHE_WORD_OFFSET_W,
    parameter int CWF           = 1,
    localparam int BE_NBYTES_W  = $clog2(BE_DATA_W / 8),
    localparam int LINE2BE_W    = WORD_OFFSET_W - $clog2(BE_DATA_W / FE_DATA_W),
    localparam int BEAT_W       = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           replace_valid_i,
    input  logic [FE_ADDR_W-BE_NBYTES_W-1:0] replace_addr_i,
    output logic                           replace_o,
    output logic                           read_valid_o,
    output logic [BEAT_W-1:0]              read_addr_o,
    output logic [BE_DATA_W-1:0]           read_rdata_o,
    output logic                           crit_valid_o,
    output logic [BE_ADDR_W-1:0]           be_addr_o,
    output logic                           be_valid_o,
    input  logic                           be_ack_i,
    input  logic [BE_DATA_W-1:0]           be_rdata_i
);

    localparam int WORD_W = FE_ADDR_W - BE_NBYTES_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]          state;
    logic [WORD_W-1:0]   word_addr;
    logic                first_beat;
    logic                accept;
    logic                fill_ack;
    logic [BEAT_W-1:0]   cur_beat;
    logic                last_beat;
    logic [WORD_W-1:0]   fetch_word;
    logic [FE_ADDR_W-1:0] fetch_byte;

    assign accept   = (state == IDLE) && replace_valid_i;
    assign fill_ack = (state == FILL) && be_ack_i;

    generate
        if (LINE2BE_W > 0) begin : g_wrap
            logic [LINE2BE_W-1:0] start_beat;

            assign start_beat = (CWF != 0) ? word_addr[LINE2BE_W-1:0] : '0;

            iob_cache_wrap_cnt #(
                .LINE2BE_W (LINE2BE_W)
            ) u_wrap_cnt (
                .clk        (clk_i),
                .reset      (reset_i),
                .clear      (accept),
                .inc        (fill_ack),
                .start_beat (start_beat),
                .beat       (cur_beat),
                .last       (last_beat)
            );

            // Keep the line tag, replace the beat field with the beat being fetched.
            assign fetch_word = {word_addr[WORD_W-1:LINE2BE_W], cur_beat};
        end else begin : g_single
            // A line is one back-end beat: nothing to sequence.
            assign cur_beat   = '0;
            assign last_beat  = 1'b1;
            assign fetch_word = word_addr;
        end
    endgenerate

    assign fetch_byte = {fetch_word, {BE_NBYTES_W{1'b0}}};
    assign be_addr_o  = BE_ADDR_W'(fetch_byte);
    assign be_valid_o = (state == FILL);
    assign replace_o  = (state != IDLE);

    // Refill sequencing: IDLE accepts a miss, FILL runs until the last beat is
    // acked, DRAIN covers the final write-back cycle before returning to IDLE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            first_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (replace_valid_i) begin
                        state      <= FILL;
                        first_beat <= 1'b1;
                    end
                end
                FILL: begin
                    if (be_ack_i) begin
                        first_beat <= 1'b0;
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Miss address captured once per refill; it holds steady for the whole fill.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            word_addr <= replace_addr_i;
        end
    end

    // Registered write-back of each acknowledged beat into the line.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            read_valid_o <= 1'b0;
            crit_valid_o <= 1'b0;
            read_addr_o  <= '0;
            read_rdata_o <= '0;
        end else begin
            read_valid_o <= fill_ack;
            crit_valid_o <= fill_ack && first_beat;
            if (fill_ack) begin
                read_addr_o  <= cur_beat;
                read_rdata_o <= be_rdata_i;
            end
        end
    end

endmodule
